// File: rtl/dmem_responder_if.sv
// Data-memory port bundle between the CPU load/store path (master)
// and the memory-side responder (slave).
interface dmem_responder_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one request at a time,
// RV32 byte-lane alignment for sb/sh/sw and lb/lh/lw/lbu/lhu, and a
// response returned WAIT_CYCLES+1 cycles after acceptance.
module dmem_responder #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0]       CNT_INIT  = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
    localparam logic [AWIDTH-3:0]   DEPTH_IDX = (AWIDTH-2)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DWIDTH-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    // Request captured at acceptance; pure data, so no reset needed
    logic              we_q;
    logic [2:0]        f3_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;

    logic [DWIDTH-1:0] mem [DEPTH];

    // Request currently being served (live inputs while idle so WAIT_CYCLES=0 works)
    logic              cur_we;
    logic [2:0]        cur_f3;
    logic [AWIDTH-1:0] cur_addr;
    logic [DWIDTH-1:0] cur_wdata;
    logic [AWIDTH-3:0] word_idx;
    logic [IW-1:0]     ram_idx;
    logic [1:0]        lane;
    logic              bad_f3, misaligned, out_of_range, acc_err;
    logic [DWIDTH-1:0] rd_word, load_data, merged, rsp_rdata_d;
    logic              accept, enter_resp, mem_we;

    // Sign/zero-extend the selected lane of a word according to the load funct3
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] ln,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{ln, 3'b000} +: 8];
        h = ln[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b010:  load_ext = w;
            3'b100:  load_ext = {24'b0, b};
            3'b101:  load_ext = {16'b0, h};
            default: load_ext = '0;
        endcase
    endfunction

    // Merge LSB-aligned store data into the old word, preserving unwritten lanes
    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] ln,
                                                input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        case (f3)
            3'b000:  r[{ln, 3'b000} +: 8] = wd[7:0];
            3'b001:  if (ln[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
            3'b010:  r = wd;
            default: r = old;
        endcase
        store_merge = r;
    endfunction

    // Select the active request and decode alignment, range and funct3 legality
    always_comb begin
        cur_we    = we_q;
        cur_f3    = f3_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            cur_we    = bus.req_we;
            cur_f3    = bus.req_funct3;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end
        word_idx     = cur_addr[AWIDTH-1:2];
        ram_idx      = word_idx[IW-1:0];
        lane         = cur_addr[1:0];
        bad_f3       = cur_we ? (cur_f3[2] || (cur_f3[1:0] == 2'b11))
                              : ((cur_f3 == 3'b011) || (cur_f3[2:1] == 2'b11));
        misaligned   = ((cur_f3[1:0] == 2'b01) && lane[0]) ||
                       ((cur_f3[1:0] == 2'b10) && (lane != 2'b00));
        out_of_range = (word_idx >= DEPTH_IDX);
        acc_err      = bad_f3 || misaligned || out_of_range;
        rd_word      = mem[ram_idx];
        load_data    = load_ext(cur_f3, lane, rd_word);
        merged       = store_merge(cur_f3, lane, rd_word, cur_wdata);
        rsp_rdata_d  = (acc_err || cur_we) ? '0 : load_data;
        accept       = req_ready_q && bus.req_valid;
        enter_resp   = ((state_q == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                       ((state_q == S_WAIT) && (cnt_q == '0));
        mem_we       = enter_resp && cur_we && !acc_err && reset;
    end

    // Capture the request fields on acceptance
    always_ff @(posedge clock) begin
        if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // Commit stores on the edge that enters RESP
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[ram_idx] <= merged;
        end
    end

    // Request/wait/response sequencing with registered handshake outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= acc_err;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= acc_err;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT_CYCLES=2 and
// one with WAIT_CYCLES=0, selected by sel, sharing the request stimulus.
module tb_dmem_responder;
    logic        clock;
    logic        reset;
    logic        sel;
    logic        req_valid, req_we, rsp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;
    int          tests;
    int          fails;

    dmem_responder_if #(.AWIDTH(32), .DWIDTH(32)) bus2 ();
    dmem_responder_if #(.AWIDTH(32), .DWIDTH(32)) bus0 ();

    dmem_responder #(.DWIDTH(32), .AWIDTH(32), .DEPTH(1024), .WAIT_CYCLES(2)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.slave)
    );

    dmem_responder #(.DWIDTH(32), .AWIDTH(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    assign bus2.req_valid  = req_valid & ~sel;
    assign bus2.req_we     = req_we;
    assign bus2.req_funct3 = req_funct3;
    assign bus2.req_addr   = req_addr;
    assign bus2.req_wdata  = req_wdata;
    assign bus2.rsp_ready  = rsp_ready & ~sel;
    assign bus0.req_valid  = req_valid & sel;
    assign bus0.req_we     = req_we;
    assign bus0.req_funct3 = req_funct3;
    assign bus0.req_addr   = req_addr;
    assign bus0.req_wdata  = req_wdata;
    assign bus0.rsp_ready  = rsp_ready & sel;

    assign o_ready = sel ? bus0.req_ready : bus2.req_ready;
    assign o_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
    assign o_rdata = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
    assign o_err   = sel ? bus0.rsp_err   : bus2.rsp_err;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: present, wait for acceptance, scramble inputs,
    // measure latency from the acceptance edge, check, then take the response.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat, input string tag);
        int n;
        int lat;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!o_ready && n < 20) begin @(posedge clock); #1; n++; end
        chk({tag, "_acc"}, {31'b0, o_ready}, 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!o_valid && lat < 20) begin @(posedge clock); #1; lat++; end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, o_rdata, exp_rd);
        chk({tag, "_err"}, {31'b0, o_err}, {31'b0, exp_err});
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        tests = 0; fails = 0;
        reset = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
        req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
        #12;
        chk("rst_ready2", {31'b0, bus2.req_ready}, 32'd1);
        chk("rst_valid2", {31'b0, bus2.rsp_valid}, 32'd0);
        chk("rst_rdata2", bus2.rsp_rdata, 32'd0);
        chk("rst_err2",   {31'b0, bus2.rsp_err}, 32'd0);
        chk("rst_ready0", {31'b0, bus0.req_ready}, 32'd1);
        chk("rst_valid0", {31'b0, bus0.rsp_valid}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Word store and load back
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3, "sw10");
        xact(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, "lw10");

        // Sub-word stores and extended loads
        xact(1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0, 3, "sb11");
        xact(1'b0, 3'b000, 32'h11, 32'h0, 32'h00000055, 1'b0, 3, "lb11");
        xact(1'b1, 3'b001, 32'h12, 32'hFFFF8001, 32'h0, 1'b0, 3, "sh12");
        xact(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 3, "lh12");
        xact(1'b0, 3'b101, 32'h12, 32'h0, 32'h00008001, 1'b0, 3, "lhu12");
        xact(1'b0, 3'b010, 32'h10, 32'h0, 32'h800155EF, 1'b0, 3, "lw10b");
        xact(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 3, "lb13");
        xact(1'b0, 3'b100, 32'h10, 32'h0, 32'h000000EF, 1'b0, 3, "lbu10");

        // Error cases leave the word untouched
        xact(1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 3, "lw13_mis");
        xact(1'b1, 3'b001, 32'h11, 32'h0000FFFF, 32'h0, 1'b1, 3, "sh11_mis");
        xact(1'b0, 3'b000, 32'h1000, 32'h0, 32'h0, 1'b1, 3, "lb_oor");
        xact(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 3, "st_badf3");
        xact(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 3, "ld_badf3");
        xact(1'b0, 3'b010, 32'h10, 32'h0, 32'h800155EF, 1'b0, 3, "lw10c");

        // Backpressure with the next request already waiting
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clock); #1;
        req_funct3 = 3'b100; req_addr = 32'h11;
        lat = 1;
        while (!o_valid && lat < 20) begin @(posedge clock); #1; lat++; end
        chk("bp_lat", 32'(lat), 32'd3);
        held = o_rdata;
        chk("bp_rdata", held, 32'h800155EF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("bp_valid_hold", {31'b0, o_valid}, 32'd1);
            chk("bp_rdata_hold", o_rdata, 32'h800155EF);
            chk("bp_ready_low", {31'b0, o_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        chk("bp_idle_ready", {31'b0, o_ready}, 32'd1);
        chk("bp_idle_valid", {31'b0, o_valid}, 32'd0);
        @(posedge clock); #1;
        chk("bp_next_acc", {31'b0, o_ready}, 32'd0);
        req_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin @(posedge clock); #1; lat++; end
        chk("bp_next_lat", 32'(lat), 32'd3);
        chk("bp_next_rdata", o_rdata, 32'h00000055);
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;

        // Zero wait states: single-cycle latency and one request per two cycles
        sel = 1'b1;
        xact(1'b1, 3'b010, 32'h40, 32'hA5A5C3C3, 32'h0, 1'b0, 1, "w0_sw40");
        xact(1'b0, 3'b010, 32'h40, 32'h0, 32'hA5A5C3C3, 1'b0, 1, "w0_lw40");
        rsp_ready = 1'b1;
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h44; req_wdata = 32'h13579BDF;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_we = 1'b0;
        chk("b2b_sw_valid", {31'b0, o_valid}, 32'd1);
        chk("b2b_sw_rdata", o_rdata, 32'h0);
        @(posedge clock); #1;
        chk("b2b_idle_ready", {31'b0, o_ready}, 32'd1);
        chk("b2b_idle_valid", {31'b0, o_valid}, 32'd0);
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("b2b_lw_valid", {31'b0, o_valid}, 32'd1);
        chk("b2b_lw_rdata", o_rdata, 32'h13579BDF);
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        sel = 1'b0;

        // Reset during the wait phase of a store abandons it
        xact(1'b1, 3'b010, 32'h20, 32'h00000000, 32'h0, 1'b0, 3, "sw20_zero");
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("rstw_accepted", {31'b0, o_ready}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("rstw_ready", {31'b0, o_ready}, 32'd1);
        chk("rstw_valid", {31'b0, o_valid}, 32'd0);
        chk("rstw_rdata", o_rdata, 32'h0);
        chk("rstw_err",   {31'b0, o_err}, 32'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        xact(1'b0, 3'b010, 32'h20, 32'h0, 32'h00000000, 1'b0, 3, "lw20");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
